// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register chain.
// Bubble word, per-stage control encoding and a saturating adder.
package pipe_pkg;

    localparam logic [31:0] NOP_WORD = 32'h0000_0013;

    typedef enum logic [1:0] {
        CTL_KEEP  = 2'd0,
        CTL_LOAD  = 2'd1,
        CTL_CLEAR = 2'd2
    } stage_ctl_t;

    function automatic logic [15:0] sat_add16(
        input logic [15:0] a,
        input logic [15:0] b
    );
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: data word plus valid bit.
// Load, clear-to-bubble and keep are mutually exclusive.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = WIDTH'(NOP_WORD)
) (
    input  logic             clk,
    input  logic             reset,
    input  stage_ctl_t       ctl,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_valid,
    output logic [WIDTH-1:0] data,
    output logic             valid
);

    // Stage register; an empty stage always holds the bubble word
    always_ff @(posedge clk) begin
        if (reset) begin
            data  <= BUBBLE;
            valid <= 1'b0;
        end else begin
            unique case (ctl)
                CTL_LOAD: begin
                    data  <= load_data;
                    valid <= load_valid;
                end
                CTL_CLEAR: begin
                    data  <= BUBBLE;
                    valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// N-stage pipeline register chain with stall, flush and hold.
// Stage 0 is IF/ID, stage STAGES-1 is MEM/WB.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter int               STAGES      = 4,
    parameter int               FLUSH_DEPTH = 2,
    parameter int               HOLD_DEPTH  = 1,
    parameter logic [WIDTH-1:0] BUBBLE      = WIDTH'(NOP_WORD),
    localparam int              OCC_W       = $clog2(STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic [WIDTH-1:0]          in_data,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      hold,
    output logic                      in_ready,
    output logic [STAGES*WIDTH-1:0]   stage_data,
    output logic [STAGES-1:0]         stage_valid,
    output logic [OCC_W-1:0]          occupancy,
    output logic [31:0]               stall_cycles,
    output logic [15:0]               bubble_count
);

    localparam logic [15:0] FLUSH_INC = 16'(FLUSH_DEPTH);

    stage_ctl_t          ctl [STAGES];
    logic [WIDTH-1:0]    src_data [STAGES];
    logic [STAGES-1:0]   src_valid;
    logic [STAGES-1:0]   next_valid;
    logic [OCC_W-1:0]    occ_next;

    assign in_ready = !(stall | (hold & !flush));

    // Each stage is fed from the stage before it; stage 0 from upstream
    always_comb begin
        src_data[0]  = in_data;
        src_valid[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            src_data[k]  = stage_data[(k-1)*WIDTH +: WIDTH];
            src_valid[k] = stage_valid[k-1];
        end
    end

    // Per-stage decode: stall > flush > hold > advance
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            ctl[k] = CTL_LOAD;
            if (stall) begin
                ctl[k] = CTL_KEEP;
            end else if (flush) begin
                ctl[k] = (k < FLUSH_DEPTH) ? CTL_CLEAR : CTL_LOAD;
            end else if (hold) begin
                if (k < HOLD_DEPTH)
                    ctl[k] = CTL_KEEP;
                else if (k == HOLD_DEPTH)
                    ctl[k] = CTL_CLEAR;
                else
                    ctl[k] = CTL_LOAD;
            end else if (k == 0 && !in_valid) begin
                ctl[k] = CTL_CLEAR;
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_stage_reg #(
            .WIDTH  (WIDTH),
            .BUBBLE (BUBBLE)
        ) u_reg (
            .clk        (clk),
            .reset      (reset),
            .ctl        (ctl[k]),
            .load_data  (src_data[k]),
            .load_valid (src_valid[k]),
            .data       (stage_data[k*WIDTH +: WIDTH]),
            .valid      (stage_valid[k])
        );
    end

    // Valid vector after the coming edge, popcounted for occupancy
    always_comb begin
        occ_next = '0;
        for (int k = 0; k < STAGES; k++) begin
            unique case (ctl[k])
                CTL_LOAD:  next_valid[k] = src_valid[k];
                CTL_CLEAR: next_valid[k] = 1'b0;
                default:   next_valid[k] = stage_valid[k];
            endcase
            if (next_valid[k])
                occ_next = occ_next + OCC_W'(1);
        end
    end

    // Occupancy tracks the valid bits presented after each edge
    always_ff @(posedge clk) begin
        if (reset)
            occupancy <= '0;
        else
            occupancy <= occ_next;
    end

    // Saturating stall and bubble counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= '0;
            bubble_count <= '0;
        end else if (stall) begin
            if (stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
        end else if (flush) begin
            bubble_count <= sat_add16(bubble_count, FLUSH_INC);
        end else if (hold) begin
            bubble_count <= sat_add16(bubble_count, 16'd1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain.
// Array model checked every cycle plus directed literal checks.
module tb_pipe_stage_chain;

    localparam int          W   = 32;
    localparam int          S   = 4;
    localparam int          FD  = 2;
    localparam int          HD  = 1;
    localparam int          OW  = $clog2(S + 1);
    localparam logic [31:0] BUB = 32'h0000_0013;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            stall;
    logic            flush;
    logic            hold;
    logic            in_ready;
    logic [S*W-1:0]  stage_data;
    logic [S-1:0]    stage_valid;
    logic [OW-1:0]   occupancy;
    logic [31:0]     stall_cycles;
    logic [15:0]     bubble_count;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_chain #(
        .WIDTH       (W),
        .STAGES      (S),
        .FLUSH_DEPTH (FD),
        .HOLD_DEPTH  (HD),
        .BUBBLE      (BUB)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .stall        (stall),
        .flush        (flush),
        .hold         (hold),
        .in_ready     (in_ready),
        .stage_data   (stage_data),
        .stage_valid  (stage_valid),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles),
        .bubble_count (bubble_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] sd(input int k);
        return stage_data[k*W +: W];
    endfunction

    // Behavioural model: arrays of entries shifted by the spec rules
    logic [W-1:0] md [S];
    logic         mv [S];
    longint       msc;
    int           mbc;
    bit           started = 0;

    always @(posedge clk) begin
        started = 1;
        if (reset) begin
            for (int k = 0; k < S; k++) begin
                md[k] = BUB;
                mv[k] = 0;
            end
            msc = 0;
            mbc = 0;
        end else if (stall) begin
            if (msc < 64'hFFFF_FFFF) msc = msc + 1;
        end else if (flush) begin
            for (int k = S - 1; k >= FD; k--) begin
                md[k] = md[k-1];
                mv[k] = mv[k-1];
            end
            for (int k = 0; k < FD; k++) begin
                md[k] = BUB;
                mv[k] = 0;
            end
            mbc = (mbc + FD > 65535) ? 65535 : mbc + FD;
        end else if (hold) begin
            for (int k = S - 1; k > HD; k--) begin
                md[k] = md[k-1];
                mv[k] = mv[k-1];
            end
            md[HD] = BUB;
            mv[HD] = 0;
            mbc = (mbc + 1 > 65535) ? 65535 : mbc + 1;
        end else begin
            for (int k = S - 1; k >= 1; k--) begin
                md[k] = md[k-1];
                mv[k] = mv[k-1];
            end
            md[0] = in_valid ? in_data : BUB;
            mv[0] = in_valid;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (started) begin
            int occ;
            occ = 0;
            for (int k = 0; k < S; k++) begin
                chk($sformatf("m_data%0d", k), 64'(sd(k)), 64'(md[k]));
                chk($sformatf("m_valid%0d", k), 64'(stage_valid[k]),
                    64'(mv[k]));
                if (mv[k]) occ++;
            end
            chk("m_occ", 64'(occupancy), 64'(occ));
            chk("m_stall_cycles", 64'(stall_cycles), 64'(msc));
            chk("m_bubble_count", 64'(bubble_count), 64'(mbc));
            chk("m_in_ready", 64'(in_ready),
                64'(!(stall || (hold && !flush))));
        end
    end

    task automatic cyc(input logic r, input logic st, input logic fl,
                       input logic ho, input logic iv,
                       input logic [W-1:0] d);
        reset    = r;
        stall    = st;
        flush    = fl;
        hold     = ho;
        in_valid = iv;
        in_data  = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; stall = 0; flush = 0; hold = 0;
        in_valid = 0; in_data = '0;
        @(posedge clk);
        #1;
        cyc(1, 0, 0, 0, 0, 0);

        // Reset state
        for (int k = 0; k < S; k++)
            chk($sformatf("rst_data%0d", k), 64'(sd(k)), 64'h13);
        chk("rst_valid", 64'(stage_valid), 64'h0);
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_stall_cnt", 64'(stall_cycles), 64'd0);
        chk("rst_bubble_cnt", 64'(bubble_count), 64'd0);

        // Fill the chain
        for (int i = 1; i <= 4; i++)
            cyc(0, 0, 0, 0, 1, W'(i));
        chk("fill_data", 64'(stage_data[127:64]), 64'h0000_0001_0000_0002);
        chk("fill_data_lo", 64'(stage_data[63:0]), 64'h0000_0003_0000_0004);
        chk("fill_valid", 64'(stage_valid), 64'hF);
        chk("fill_occ", 64'(occupancy), 64'd4);

        // Stall three cycles
        stall = 1; #1;
        chk("stall_ready", 64'(in_ready), 64'd0);
        repeat (3) cyc(0, 1, 0, 0, 1, 32'h99);
        chk("stall_s0", 64'(sd(0)), 64'h4);
        chk("stall_s3", 64'(sd(3)), 64'h1);
        chk("stall_cnt3", 64'(stall_cycles), 64'd3);
        cyc(0, 0, 0, 0, 1, 32'h5);
        chk("resume_s0", 64'(sd(0)), 64'h5);
        chk("resume_s1", 64'(sd(1)), 64'h4);
        chk("resume_s3", 64'(sd(3)), 64'h2);

        // Flush with 0xB/0xA in stages 0/1
        cyc(0, 0, 0, 0, 1, 32'hA);
        cyc(0, 0, 0, 0, 1, 32'hB);
        cyc(0, 0, 1, 0, 1, 32'hEE);
        chk("flush_s0", 64'(sd(0)), 64'h13);
        chk("flush_s1", 64'(sd(1)), 64'h13);
        chk("flush_s2", 64'(sd(2)), 64'hA);
        chk("flush_valid", 64'(stage_valid), 64'b1100);
        chk("flush_bubbles", 64'(bubble_count), 64'd2);

        // Load-use hold with 0xC in stage 0
        cyc(0, 0, 0, 0, 1, 32'hC);
        hold = 1; in_valid = 1; in_data = 32'hD; #1;
        chk("hold_ready", 64'(in_ready), 64'd0);
        cyc(0, 0, 0, 1, 1, 32'hD);
        chk("hold_s0", 64'(sd(0)), 64'hC);
        chk("hold_s1", 64'(sd(1)), 64'h13);
        chk("hold_valid", 64'(stage_valid), 64'b0001);
        chk("hold_bubbles", 64'(bubble_count), 64'd3);
        cyc(0, 0, 0, 0, 1, 32'hD);
        chk("after_hold_s0", 64'(sd(0)), 64'hD);
        chk("after_hold_s1", 64'(sd(1)), 64'hC);

        // Stall, flush and hold together, then stall drops
        repeat (2) cyc(0, 1, 1, 1, 1, 32'h77);
        chk("sfh_s0", 64'(sd(0)), 64'hD);
        chk("sfh_valid", 64'(stage_valid), 64'b0011);
        chk("sfh_stall_cnt", 64'(stall_cycles), 64'd5);
        stall = 0; #1;
        chk("fh_ready", 64'(in_ready), 64'd1);
        cyc(0, 0, 1, 1, 1, 32'h77);
        chk("fh_s2", 64'(sd(2)), 64'hC);
        chk("fh_valid", 64'(stage_valid), 64'b0100);
        chk("fh_bubbles", 64'(bubble_count), 64'd5);

        // Reset mid-stream while stalled
        cyc(0, 0, 0, 0, 1, 32'h21);
        cyc(0, 0, 0, 0, 1, 32'h22);
        cyc(1, 1, 1, 0, 1, 32'h23);
        chk("mrst_valid", 64'(stage_valid), 64'h0);
        chk("mrst_s0", 64'(sd(0)), 64'h13);
        chk("mrst_s3", 64'(sd(3)), 64'h13);
        chk("mrst_stall_cnt", 64'(stall_cycles), 64'd0);
        chk("mrst_bubbles", 64'(bubble_count), 64'd0);
        chk("mrst_occ", 64'(occupancy), 64'd0);

        // Bubble counter saturation
        for (int i = 0; i < 32768; i++)
            cyc(0, 0, 1, 0, 1, W'(i));
        chk("sat_bubbles", 64'(bubble_count), 64'hFFFF);
        cyc(0, 0, 0, 1, 1, 32'h1);
        chk("sat_bubbles_hold", 64'(bubble_count), 64'hFFFF);
        cyc(0, 0, 0, 0, 0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
